wta_disparity_select: RTL and testbench
=======================================

# wta_disparity_select

Winner-take-all disparity selector directly downstream of the SAD cost stage. Each valid beat carries MAX_SAMPLES_PER_CLOCK cost vectors of MAX_DISP 8-bit SAD values. For each vector the block finds the argmin through a registered comparator tree, applies a cost-threshold and left-border validity check, and emits one disparity index per sample on a tready-less AXI-Stream-style master port toward the disparity post-processing / output stage.

## Interface
- WIDTH, 740, pixels per line (column counter saturation bound)
- MAX_DISP, 64, cost entries per sample; power of two, ≥2
- MAX_SAMPLES_PER_CLOCK, 4, samples per beat (P)
- DATA_WIDTH, 8, SAD cost width
- COST_THRESHOLD, 255, minimum cost strictly above this marks the sample invalid (255 disables for DATA_WIDTH=8)
- INVALID_DISP, 0, disparity value emitted for invalid samples
- DISP_W, $clog2(MAX_DISP), derived output width (localparam)

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tvalid  in  1  input beat valid; no back-pressure, every valid beat is consumed
- s_axis_tdata  in  [P-1:0][MAX_DISP-1:0][DATA_WIDTH-1:0]  cost vectors; [p][d] = cost of sample p at disparity d
- s_axis_tlast  in  1  last beat of line
- s_axis_tuser  in  1  first beat of frame
- m_axis_tvalid  out  1  output beat valid
- m_axis_tdata  out  [P-1:0][DISP_W-1:0]  selected disparity per sample
- m_axis_tmask  out  P  1 = sample p valid, 0 = forced to INVALID_DISP
- m_axis_tlast  out  1  delayed s_axis_tlast
- m_axis_tuser  out  1  delayed s_axis_tuser

## Operation
- Stage 0 (input register): capture tdata, tvalid, tlast, tuser; compute per-sample border mask from column counter.
- Column counter col_base, width $clog2(WIDTH+P): on valid beat with tuser=1 that beat uses col_base=0. Sample p has column col_base+p. After a valid beat: tlast=1 → 0; else col_base+P, saturating at WIDTH. Non-valid cycles: unchanged.
- Border rule: sample p border-valid iff column ≥ MAX_DISP-1.
- Tree stages 1..DISP_W: each stage halves candidate pairs {cost, index}; comparator keeps left (lower index) on cost_left ≤ cost_right, so ties resolve to the lowest disparity. One register level per stage. valid/last/user/border mask shift in lockstep with data.
- Final stage: if mincost > COST_THRESHOLD or border-invalid → tdata[p]=INVALID_DISP, tmask[p]=0; else tdata[p]=argmin index, tmask[p]=1. Threshold compare is unsigned, DATA_WIDTH bits; no arithmetic widening.
- Pipeline free-runs every cycle; bubbles (tvalid=0) propagate as tvalid=0 with data don't-care but registered.

## Timing
- Latency LAT = DISP_W+1 cycles: s_axis_tvalid at edge n → m_axis_tvalid at edge n+LAT (7 for MAX_DISP=64).
- Throughput: one beat (P disparities) per cycle, any valid pattern.
- m_axis_tlast/tuser only asserted together with m_axis_tvalid; tuser and tlast on the same beat both honored (col_base=0 for that beat, then 0).
- Reset: all outputs 0 (tvalid, tlast, tuser, tdata, tmask), all pipe valid bits 0, col_base 0. Reset mid-stream drops all in-flight beats; first beat after release is treated as column col_base=0 even without tuser.
- Reset deassertion needs no synchronisation inside block; integration provides release synchronous to aclk.

## Test plan
- MAX_DISP=64, P=4, col_base≥63: sample 0 costs all 200 except d=17 → 5 → after 7 cycles tdata[0]=17, tmask[0]=1, tvalid=1 for exactly one cycle.
- Tie: costs d=3 and d=40 both 10, rest 255 → tdata=3; all costs equal 0 → tdata=0, tmask=1.
- COST_THRESHOLD=50: min cost 60 at d=9 → tdata=0, tmask=0; min cost 50 at d=9 → tdata=9, tmask=1.
- Border: tuser beat then 16 consecutive beats → beats 0..14 tmask=0000; beat 15 (cols 60..63) tmask=1000 (sample 3 only); beat 16 tmask=1111; tlast on beat 20 → next beat masked again.
- Irregular valid pattern 1,0,0,1,1,0,1 with tlast on 4th valid beat → output valid pattern identical shifted by 7, tlast aligned with 4th output beat.
- Assert areset for 1 cycle while 5 beats in flight → outputs 0 immediately (async), none of the 5 beats emerge, col_base restarts at 0.

Source files
------------

// File: rtl/wta_disparity_select.sv
// rtl/wta_disparity_select.sv - winner-take-all disparity selector after the SAD cost stage
//
// Each valid beat carries MAX_SAMPLES_PER_CLOCK cost vectors of MAX_DISP costs.
// The argmin of every vector is found through a registered binary comparator
// tree, then gated by a cost threshold and a left-border column check.
//
// Ports:
//   aclk, areset         clock, asynchronous active-high reset
//   s_axis_tvalid/tdata  input beat: [p][d] = cost of sample p at disparity d
//   s_axis_tlast/tuser   end of line / start of frame
//   m_axis_tvalid/tdata  output beat: selected disparity per sample
//   m_axis_tmask         per-sample validity (0 = forced to INVALID_DISP)
//   m_axis_tlast/tuser   delayed s_axis_tlast / s_axis_tuser
module wta_disparity_select #(
    parameter int WIDTH                 = 740,
    parameter int MAX_DISP              = 64,
    parameter int MAX_SAMPLES_PER_CLOCK = 4,
    parameter int DATA_WIDTH            = 8,
    parameter int COST_THRESHOLD        = 255,
    parameter int INVALID_DISP          = 0,
    localparam int DISP_W               = $clog2(MAX_DISP),
    localparam int P                    = MAX_SAMPLES_PER_CLOCK
) (
    input  logic                                       aclk,
    input  logic                                       areset,
    input  logic                                       s_axis_tvalid,
    input  logic [P-1:0][MAX_DISP-1:0][DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                                       s_axis_tlast,
    input  logic                                       s_axis_tuser,
    output logic                                       m_axis_tvalid,
    output logic [P-1:0][DISP_W-1:0]                   m_axis_tdata,
    output logic [P-1:0]                               m_axis_tmask,
    output logic                                       m_axis_tlast,
    output logic                                       m_axis_tuser
);

    localparam int CW    = $clog2(WIDTH + P);
    localparam int CW1   = CW + 1;
    // All tree levels are stored back to back: level 0 (the raw costs) at
    // [0, MAX_DISP), level 1 right after it, ..., the root at NODES-1.
    localparam int NODES = 2 * MAX_DISP - 1;
    localparam int ROOT  = NODES - 1;

    localparam logic [DATA_WIDTH-1:0] THR      = DATA_WIDTH'(COST_THRESHOLD);
    localparam logic [CW1-1:0]        WIDTH_C  = CW1'(WIDTH);
    localparam logic [CW1-1:0]        BORDER_C = CW1'(MAX_DISP - 1);

    function automatic int lvl_off(input int s);
        return 2 * MAX_DISP - 2 * (MAX_DISP >> s);
    endfunction

    // ------------------------------------------------------------------
    // Column tracking and left-border mask (computed ahead of stage 0)
    // ------------------------------------------------------------------
    logic [CW-1:0]  col_base;
    logic [CW1-1:0] eff_base;
    logic [CW1-1:0] next_sum;
    logic [P-1:0]   border_in;

    always_comb begin
        // A frame-start beat is always column 0, whatever the counter says.
        eff_base  = s_axis_tuser ? '0 : {1'b0, col_base};
        next_sum  = eff_base + CW1'(P);
        border_in = '0;
        for (int p = 0; p < P; p++) begin
            border_in[p] = (eff_base + CW1'(p)) >= BORDER_C;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            col_base <= '0;
        end else if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
                col_base <= '0;
            end else if (next_sum > WIDTH_C) begin
                col_base <= WIDTH_C[CW-1:0];
            end else begin
                col_base <= next_sum[CW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Comparator tree: stage 0 loads the costs, each later stage halves
    // the candidate count. Data registers free-run and carry no reset.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] node_cost   [P][NODES];
    logic [DISP_W-1:0]     node_idx    [P][NODES];
    logic [DATA_WIDTH-1:0] node_cost_d [P][NODES];
    logic [DISP_W-1:0]     node_idx_d  [P][NODES];

    always_comb begin
        node_cost_d = node_cost;
        node_idx_d  = node_idx;
        for (int p = 0; p < P; p++) begin
            for (int d = 0; d < MAX_DISP; d++) begin
                node_cost_d[p][d] = s_axis_tdata[p][d];
                node_idx_d[p][d]  = DISP_W'(d);
            end
            for (int s = 1; s <= DISP_W; s++) begin
                for (int k = 0; k < (MAX_DISP >> s); k++) begin
                    // '<=' keeps the left (lower disparity) candidate on ties.
                    if (node_cost[p][lvl_off(s-1) + 2*k] <= node_cost[p][lvl_off(s-1) + 2*k + 1]) begin
                        node_cost_d[p][lvl_off(s) + k] = node_cost[p][lvl_off(s-1) + 2*k];
                        node_idx_d[p][lvl_off(s) + k]  = node_idx[p][lvl_off(s-1) + 2*k];
                    end else begin
                        node_cost_d[p][lvl_off(s) + k] = node_cost[p][lvl_off(s-1) + 2*k + 1];
                        node_idx_d[p][lvl_off(s) + k]  = node_idx[p][lvl_off(s-1) + 2*k + 1];
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        node_cost <= node_cost_d;
        node_idx  <= node_idx_d;
    end

    // ------------------------------------------------------------------
    // Sideband pipeline (bit i aligned with tree level i) and output stage
    // ------------------------------------------------------------------
    logic [DISP_W:0]        vld_pipe;
    logic [DISP_W:0]        last_pipe;
    logic [DISP_W:0]        user_pipe;
    logic [DISP_W:0][P-1:0] border_pipe;

    logic [P-1:0][DISP_W-1:0] out_data_d;
    logic [P-1:0]             out_mask_d;

    always_comb begin
        out_data_d = '0;
        out_mask_d = '0;
        for (int p = 0; p < P; p++) begin
            if (border_pipe[DISP_W][p] && (node_cost[p][ROOT] <= THR)) begin
                out_data_d[p] = node_idx[p][ROOT];
                out_mask_d[p] = 1'b1;
            end else begin
                out_data_d[p] = DISP_W'(INVALID_DISP);
                out_mask_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_pipe      <= '0;
            last_pipe     <= '0;
            user_pipe     <= '0;
            border_pipe   <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tmask  <= '0;
        end else begin
            vld_pipe      <= {vld_pipe[DISP_W-1:0], s_axis_tvalid};
            // Qualify sidebands at entry so they can never appear on a bubble.
            last_pipe     <= {last_pipe[DISP_W-1:0], s_axis_tvalid & s_axis_tlast};
            user_pipe     <= {user_pipe[DISP_W-1:0], s_axis_tvalid & s_axis_tuser};
            border_pipe   <= {border_pipe[DISP_W-1:0], border_in};
            m_axis_tvalid <= vld_pipe[DISP_W];
            m_axis_tlast  <= last_pipe[DISP_W];
            m_axis_tuser  <= user_pipe[DISP_W];
            m_axis_tdata  <= out_data_d;
            m_axis_tmask  <= out_mask_d;
        end
    end

endmodule

// File: tb/tb_wta_disparity_select.sv
// tb/tb_wta_disparity_select.sv - scoreboard bench for wta_disparity_select
module tb_wta_disparity_select;

    localparam int P   = 4;
    localparam int D   = 64;
    localparam int DW  = 6;
    localparam int THR = 50;
    localparam int LAT = 7;

    typedef logic [P-1:0][D-1:0][7:0] beat_t;
    typedef logic [P-1:0][DW-1:0]     disp_t;
    typedef struct {
        disp_t        data;
        logic [P-1:0] mask;
        logic         last;
        logic         user;
        int           cyc;
        int           id;
    } exp_t;

    logic         aclk;
    logic         areset;
    logic         s_axis_tvalid;
    beat_t        s_axis_tdata;
    logic         s_axis_tlast;
    logic         s_axis_tuser;
    logic         m_axis_tvalid;
    disp_t        m_axis_tdata;
    logic [P-1:0] m_axis_tmask;
    logic         m_axis_tlast;
    logic         m_axis_tuser;

    wta_disparity_select #(
        .WIDTH                 (740),
        .MAX_DISP              (D),
        .MAX_SAMPLES_PER_CLOCK (P),
        .DATA_WIDTH            (8),
        .COST_THRESHOLD        (THR),
        .INVALID_DISP          (0)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tmask  (m_axis_tmask),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   beat_id    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic vld, input beat_t data, input logic last, input logic user);
        @(posedge aclk);
        #1;
        s_axis_tvalid = vld;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
    endtask

    task automatic send(input beat_t data, input logic last, input logic user,
                        input disp_t ed, input logic [P-1:0] em);
        exp_t e;
        drive(1'b1, data, last, user);
        e.data = ed;
        e.mask = em;
        e.last = last;
        e.user = user;
        e.cyc  = cyc + LAT + 1;
        e.id   = beat_id;
        beat_id++;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        drive(1'b0, '0, 1'b0, 1'b0);
        while (sb.size() != 0 && n < budget) begin
            @(posedge aclk);
            n++;
        end
        check("drain_pending_beats", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every output beat is matched against the head of the scoreboard.
    always @(negedge aclk) begin : monitor
        exp_t e;
        if (m_axis_tvalid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got tdata %0h tmask %0h with none expected",
                         m_axis_tdata, m_axis_tmask);
            end else begin
                e = sb.pop_front();
                check($sformatf("beat%0d_tdata", e.id), 64'(m_axis_tdata), 64'(e.data));
                check($sformatf("beat%0d_tmask", e.id), 64'(m_axis_tmask), 64'(e.mask));
                check($sformatf("beat%0d_tlast", e.id), 64'(m_axis_tlast), 64'(e.last));
                check($sformatf("beat%0d_tuser", e.id), 64'(m_axis_tuser), 64'(e.user));
                check($sformatf("beat%0d_cycle", e.id), 64'(cyc), 64'(e.cyc));
            end
        end else begin
            check("idle_last_user", {62'd0, m_axis_tlast, m_axis_tuser}, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        beat_t        v;
        disp_t        ed;
        logic [P-1:0] em;
        int           d;
        int           j;

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset_tlast",  64'(m_axis_tlast),  64'd0);
        check("reset_tuser",  64'(m_axis_tuser),  64'd0);
        check("reset_tdata",  64'(m_axis_tdata),  64'd0);
        check("reset_tmask",  64'(m_axis_tmask),  64'd0);
        areset = 1'b0;

        // Border ramp: frame start, tlast on beat 20, then a new line.
        for (int k = 0; k <= 40; k++) begin
            j  = (k <= 20) ? k : k - 21;
            em = (j < 15) ? 4'b0000 : (j == 15) ? 4'b1000 : 4'b1111;
            v  = {(P*D){8'd100}};
            ed = '0;
            for (int p = 0; p < P; p++) begin
                d = (k * 3 + p * 17) % 64;
                v[p][d] = 8'd7;
                ed[p] = em[p] ? DW'(d) : DW'(0);
            end
            send(v, k == 20, k == 0, ed, em);
        end
        drain(40);

        // Single minimum at d=17; other samples all-equal resolve to 0.
        v = {(P*D){8'd30}};
        v[0] = {D{8'd200}};
        v[0][17] = 8'd5;
        ed = '0;
        ed[0] = DW'(17);
        send(v, 1'b0, 1'b0, ed, 4'b1111);

        // Ties, all-zero vector, threshold just above / at the limit.
        v = '0;
        v[0] = {D{8'd255}}; v[0][3] = 8'd10; v[0][40] = 8'd10;
        v[2] = {D{8'd200}}; v[2][9] = 8'd60;
        v[3] = {D{8'd200}}; v[3][9] = 8'd50;
        ed = '0;
        ed[0] = DW'(3);
        ed[3] = DW'(9);
        send(v, 1'b0, 1'b0, ed, 4'b1011);

        // Tie across the root halves, highest index, threshold+1 everywhere.
        v[0] = {D{8'd9}};   v[0][31] = 8'd1; v[0][32] = 8'd1;
        v[1] = {D{8'd255}}; v[1][63] = 8'd0;
        v[2] = {D{8'd51}};
        v[3] = {D{8'd40}};  v[3][62] = 8'd3; v[3][63] = 8'd3;
        ed = '0;
        ed[0] = DW'(31);
        ed[1] = DW'(63);
        ed[3] = DW'(62);
        send(v, 1'b0, 1'b0, ed, 4'b1011);
        drain(40);

        // Irregular valid pattern 1,0,0,1,1,0,1 with tlast on 4th valid beat.
        j = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 3 || i == 4 || i == 6) begin
                v = {(P*D){8'd20}};
                v[0] = {D{8'd100}};
                v[0][10 + i] = 8'd1;
                ed = '0;
                ed[0] = DW'(10 + i);
                j++;
                send(v, j == 4, 1'b0, ed, 4'b1111);
            end else begin
                drive(1'b0, '0, 1'b0, 1'b0);
            end
        end
        drain(40);

        // New line up to column 63, then reset with five beats in flight.
        for (int k = 0; k < 16; k++) begin
            em = (k < 15) ? 4'b0000 : 4'b1000;
            v  = {(P*D){8'd20}};
            ed = '0;
            for (int p = 0; p < P; p++) begin
                v[p][p + 1] = 8'd2;
                ed[p] = em[p] ? DW'(p + 1) : DW'(0);
            end
            send(v, 1'b0, 1'b0, ed, em);
        end
        drain(40);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, v, 1'b0, 1'b0);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        #1;
        check("async_reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("async_reset_tdata",  64'(m_axis_tdata),  64'd0);
        check("async_reset_tmask",  64'(m_axis_tmask),  64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (12) drive(1'b0, '0, 1'b0, 1'b0);

        // Column counter restarts at 0 without tuser.
        send(v, 1'b0, 1'b0, '0, 4'b0000);
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
